// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: bus widths, constant words,
// write-enable levels, load funct3 codes and the FSM state encoding.
package wb_stage_pkg;

    localparam int REG_BUS_W      = 32;
    localparam int REG_ADDR_BUS_W = 5;

    localparam logic [REG_BUS_W-1:0]      ZERO_WORD     = 32'h0000_0000;
    localparam logic [REG_ADDR_BUS_W-1:0] ZERO_ADDR     = 5'd0;
    localparam logic                      WRITE_ENABLE  = 1'b1;
    localparam logic                      WRITE_DISABLE = 1'b0;

    // Load funct3 codes
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'b00,
        WB_WAIT  = 2'b01,
        WB_WRITE = 2'b10
    } wb_state_e;

    // A write is only issued when rd is written and rd is not x0.
    function automatic logic wb_wen(input logic wreg, input logic [REG_ADDR_BUS_W-1:0] waddr);
        return wreg && (waddr != ZERO_ADDR);
    endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Load data aligner / extender (purely combinational).
// Ports:
//   rdata_i    [31:0] raw read word from data memory
//   funct3_i   [2:0]  load type (LB/LH/LW/LBU/LHU)
//   offset_i   [1:0]  byte offset of the load address
//   ext_data_o [31:0] aligned, sign/zero-extended result (0 for unknown funct3)
module wb_load_ext
    import wb_stage_pkg::*;
(
    input  logic [REG_BUS_W-1:0] rdata_i,
    input  logic [2:0]           funct3_i,
    input  logic [1:0]           offset_i,
    output logic [REG_BUS_W-1:0] ext_data_o
);

    logic [REG_BUS_W-1:0] shifted_s;

    // Move the addressed byte/halfword to bit 0 and extend per load type
    always_comb begin
        shifted_s  = rdata_i >> {offset_i, 3'b000};
        ext_data_o = ZERO_WORD;
        case (funct3_i)
            LD_LB:   ext_data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            LD_LBU:  ext_data_o = {24'h00_0000, shifted_s[7:0]};
            LD_LH:   ext_data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            LD_LHU:  ext_data_o = {16'h0000, shifted_s[15:0]};
            LD_LW:   ext_data_o = rdata_i;   // word loads are always aligned
            default: ext_data_o = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: takes one retiring instruction from the memory stage,
// waits for the data-memory response on loads, extends load data and issues
// exactly one single-cycle register-file write per instruction (never to x0).
// Optional feature macro: WB_LOAD_TIMEOUT_EN (abandon a load after
// LOAD_TIMEOUT cycles in WAIT and pulse load_err_o).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush_i               discard held and pending work
//   mem_*                 instruction presented by the memory stage
//   dmem_rvalid_i/rdata_i data-memory read response
//   stall_o               upstream hold while a load response is outstanding
//   we_o/waddr_o/wdata_o  register-file write port (registered)
//   load_err_o            load timeout pulse (0 without the feature)
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 255,
    parameter int TO_W         = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      mem_valid_i,
    input  logic                      mem_wreg_i,
    input  logic [REG_ADDR_BUS_W-1:0] mem_waddr_i,
    input  logic [REG_BUS_W-1:0]      mem_wdata_i,
    input  logic                      mem_is_load_i,
    input  logic [2:0]                mem_ld_funct3_i,
    input  logic [1:0]                mem_addr_lo_i,
    input  logic                      dmem_rvalid_i,
    input  logic [REG_BUS_W-1:0]      dmem_rdata_i,
    output logic                      stall_o,
    output logic                      we_o,
    output logic [REG_ADDR_BUS_W-1:0] waddr_o,
    output logic [REG_BUS_W-1:0]      wdata_o,
    output logic                      load_err_o
);

    // The timeout counter must be able to hold LOAD_TIMEOUT
    if (TO_W < 1 || LOAD_TIMEOUT < 1 || LOAD_TIMEOUT >= (1 << TO_W)) begin : g_param_check
        $error("wb_stage: TO_W too narrow for LOAD_TIMEOUT");
    end

    wb_state_e                 state_r, state_nx;
    logic                      we_r, we_nx;
    logic [REG_ADDR_BUS_W-1:0] waddr_r, waddr_nx;
    logic [REG_BUS_W-1:0]      wdata_r, wdata_nx;
    logic                      ld_wen_r, ld_wen_nx;
    logic [REG_ADDR_BUS_W-1:0] ld_waddr_r, ld_waddr_nx;
    logic [2:0]                ld_funct3_r, ld_funct3_nx;
    logic [1:0]                ld_off_r, ld_off_nx;
    logic [REG_BUS_W-1:0]      ld_ext_s;
`ifdef WB_LOAD_TIMEOUT_EN
    logic [TO_W-1:0]           to_cnt_r, to_cnt_nx;
    logic                      err_r, err_nx;
`endif

    wb_load_ext u_load_ext (
        .rdata_i    (dmem_rdata_i),
        .funct3_i   (ld_funct3_r),
        .offset_i   (ld_off_r),
        .ext_data_o (ld_ext_s)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= WB_IDLE;
            we_r        <= WRITE_DISABLE;
            waddr_r     <= ZERO_ADDR;
            wdata_r     <= ZERO_WORD;
            ld_wen_r    <= 1'b0;
            ld_waddr_r  <= ZERO_ADDR;
            ld_funct3_r <= 3'b000;
            ld_off_r    <= 2'b00;
`ifdef WB_LOAD_TIMEOUT_EN
            to_cnt_r    <= {TO_W{1'b0}};
            err_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_nx;
            we_r        <= we_nx;
            waddr_r     <= waddr_nx;
            wdata_r     <= wdata_nx;
            ld_wen_r    <= ld_wen_nx;
            ld_waddr_r  <= ld_waddr_nx;
            ld_funct3_r <= ld_funct3_nx;
            ld_off_r    <= ld_off_nx;
`ifdef WB_LOAD_TIMEOUT_EN
            to_cnt_r    <= to_cnt_nx;
            err_r       <= err_nx;
`endif
        end
    end

    // Next-state logic: flush beats a response, and a response is only
    // honoured in WAIT; WRITE accepts new work exactly like IDLE.
    always_comb begin
        state_nx     = state_r;
        we_nx        = WRITE_DISABLE;
        waddr_nx     = waddr_r;
        wdata_nx     = wdata_r;
        ld_wen_nx    = ld_wen_r;
        ld_waddr_nx  = ld_waddr_r;
        ld_funct3_nx = ld_funct3_r;
        ld_off_nx    = ld_off_r;
`ifdef WB_LOAD_TIMEOUT_EN
        to_cnt_nx    = to_cnt_r;
        err_nx       = 1'b0;
`endif
        if (flush_i) begin
            state_nx = WB_IDLE;
        end else if (state_r == WB_WAIT) begin
            if (dmem_rvalid_i) begin
                state_nx = WB_WRITE;
                we_nx    = ld_wen_r;
                waddr_nx = ld_waddr_r;
                wdata_nx = ld_ext_s;
`ifdef WB_LOAD_TIMEOUT_EN
            end else if (to_cnt_r == TO_W'(LOAD_TIMEOUT - 1)) begin
                // This is the LOAD_TIMEOUT-th WAIT cycle without a response
                state_nx = WB_IDLE;
                err_nx   = 1'b1;
            end else begin
                to_cnt_nx = to_cnt_r + TO_W'(1);
            end
`else
            end else begin
                state_nx = WB_WAIT;
            end
`endif
        end else if (mem_valid_i) begin
            if (mem_is_load_i) begin
                state_nx     = WB_WAIT;
                ld_wen_nx    = wb_wen(mem_wreg_i, mem_waddr_i);
                ld_waddr_nx  = mem_waddr_i;
                ld_funct3_nx = mem_ld_funct3_i;
                ld_off_nx    = mem_addr_lo_i;
`ifdef WB_LOAD_TIMEOUT_EN
                to_cnt_nx    = {TO_W{1'b0}};
`endif
            end else begin
                state_nx = WB_IDLE;
                we_nx    = wb_wen(mem_wreg_i, mem_waddr_i);
                waddr_nx = mem_waddr_i;
                wdata_nx = mem_wdata_i;
            end
        end else begin
            state_nx = WB_IDLE;
        end
    end

    assign stall_o = (state_r == WB_WAIT);
    assign we_o    = we_r;
    assign waddr_o = waddr_r;
    assign wdata_o = wdata_r;
`ifdef WB_LOAD_TIMEOUT_EN
    assign load_err_o = err_r;
`else
    assign load_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        mem_valid_i;
    logic        mem_wreg_i;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_is_load_i;
    logic [2:0]  mem_ld_funct3_i;
    logic [1:0]  mem_addr_lo_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        load_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_stage #(.LOAD_TIMEOUT(4), .TO_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .mem_valid_i     (mem_valid_i),
        .mem_wreg_i      (mem_wreg_i),
        .mem_waddr_i     (mem_waddr_i),
        .mem_wdata_i     (mem_wdata_i),
        .mem_is_load_i   (mem_is_load_i),
        .mem_ld_funct3_i (mem_ld_funct3_i),
        .mem_addr_lo_i   (mem_addr_lo_i),
        .dmem_rvalid_i   (dmem_rvalid_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .stall_o         (stall_o),
        .we_o            (we_o),
        .waddr_o         (waddr_o),
        .wdata_o         (wdata_o),
        .load_err_o      (load_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // advance one clock and land 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i = 1'b0; mem_valid_i = 1'b0; mem_wreg_i = 1'b0; mem_waddr_i = 5'd0;
        mem_wdata_i = 32'h0; mem_is_load_i = 1'b0; mem_ld_funct3_i = 3'b000;
        mem_addr_lo_i = 2'b00; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    endtask

    task automatic present_alu(input logic [4:0] rd, input logic [31:0] d);
        mem_valid_i = 1'b1; mem_wreg_i = 1'b1; mem_is_load_i = 1'b0;
        mem_waddr_i = rd; mem_wdata_i = d;
    endtask

    task automatic present_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd);
        mem_valid_i = 1'b1; mem_wreg_i = 1'b1; mem_is_load_i = 1'b1;
        mem_ld_funct3_i = f3; mem_addr_lo_i = off; mem_waddr_i = rd;
    endtask

    // capture a load, respond after 'lat' WAIT cycles, check the write
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] off,
                           input logic [4:0] rd, input logic [31:0] rdata, input int lat,
                           input logic [31:0] exp);
        present_load(f3, off, rd);
        tick();
        mem_valid_i = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check({tag, "_stall"}, {31'd0, stall_o}, 32'd1);
            check({tag, "_we_wait"}, {31'd0, we_o}, 32'd0);
            if (i == lat - 1) begin
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = rdata;
            end
            tick();
        end
        dmem_rvalid_i = 1'b0;
        check({tag, "_we"}, {31'd0, we_o}, 32'd1);
        check({tag, "_waddr"}, {27'd0, waddr_o}, {27'd0, rd});
        check({tag, "_wdata"}, wdata_o, exp);
        check({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
        tick();
        check({tag, "_we_pulse"}, {31'd0, we_o}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_we", {31'd0, we_o}, 32'd0);
        check("rst_waddr", {27'd0, waddr_o}, 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_err", {31'd0, load_err_o}, 32'd0);

        // ADD x5 = 0x1234
        present_alu(5'd5, 32'h0000_1234);
        tick();
        mem_valid_i = 1'b0;
        check("add_we", {31'd0, we_o}, 32'd1);
        check("add_waddr", {27'd0, waddr_o}, 32'd5);
        check("add_wdata", wdata_o, 32'h0000_1234);
        tick();
        check("add_we_pulse", {31'd0, we_o}, 32'd0);

        // ALU op with wreg=0 never writes
        present_alu(5'd6, 32'h1111_1111);
        mem_wreg_i = 1'b0;
        tick();
        mem_valid_i = 1'b0;
        check("nowreg_we", {31'd0, we_o}, 32'd0);

        // response in the capture cycle must be ignored
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFFFF_FFFF;
        present_load(3'b000, 2'd2, 5'd7);
        tick();
        dmem_rvalid_i = 1'b0;
        check("cap_resp_stall", {31'd0, stall_o}, 32'd1);
        check("cap_resp_we", {31'd0, we_o}, 32'd0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h0080_0000;
        mem_valid_i   = 1'b0;
        tick();
        dmem_rvalid_i = 1'b0;
        check("cap_resp_wdata", wdata_o, 32'hFFFF_FF80);
        tick();

        do_load("lb",   3'b000, 2'd2, 5'd7,  32'h0080_0000, 3, 32'hFFFF_FF80);
        do_load("lbu",  3'b100, 2'd2, 5'd8,  32'h0080_0000, 3, 32'h0000_0080);
        do_load("lh",   3'b001, 2'd2, 5'd9,  32'h8001_ABCD, 1, 32'hFFFF_8001);
        do_load("lhu",  3'b101, 2'd0, 5'd10, 32'h8001_ABCD, 2, 32'h0000_ABCD);
        do_load("lw",   3'b010, 2'd3, 5'd11, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
        do_load("lb3",  3'b000, 2'd3, 5'd12, 32'h7F00_0000, 1, 32'h0000_007F);
        do_load("bad3", 3'b011, 2'd0, 5'd13, 32'hCAFE_F00D, 1, 32'h0000_0000);

        // LW x0 back-to-back with ADD x0, then ADD x9: no write to x0, no bubble
        present_load(3'b010, 2'd0, 5'd0);
        tick();
        present_alu(5'd0, 32'h0000_0055);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1234_5678;
        tick();
        dmem_rvalid_i = 1'b0;
        check("x0_lw_we", {31'd0, we_o}, 32'd0);
        check("x0_lw_stall", {31'd0, stall_o}, 32'd0);
        tick();
        check("x0_add_we", {31'd0, we_o}, 32'd0);
        present_alu(5'd9, 32'h0000_0099);
        tick();
        mem_valid_i = 1'b0;
        check("b2b_we", {31'd0, we_o}, 32'd1);
        check("b2b_waddr", {27'd0, waddr_o}, 32'd9);
        check("b2b_wdata", wdata_o, 32'h0000_0099);
        tick();

        // flush in WAIT beats a simultaneous response; later stray rvalid ignored
        present_load(3'b000, 2'd0, 5'd6);
        tick();
        mem_valid_i   = 1'b0;
        flush_i       = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h0000_0042;
        tick();
        flush_i = 1'b0;
        check("flush_we", {31'd0, we_o}, 32'd0);
        check("flush_stall", {31'd0, stall_o}, 32'd0);
        tick();
        dmem_rvalid_i = 1'b0;
        check("stray_we", {31'd0, we_o}, 32'd0);
        check("stray_stall", {31'd0, stall_o}, 32'd0);

        // flush beats capture
        present_alu(5'd8, 32'h0000_0088);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        mem_valid_i = 1'b0;
        check("flush_cap_we", {31'd0, we_o}, 32'd0);

        // no response: timeout (feature) or indefinite wait
        present_load(3'b010, 2'd0, 5'd14);
        tick();
        mem_valid_i = 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_stall", {31'd0, stall_o}, 32'd1);
            check("to_err_early", {31'd0, load_err_o}, 32'd0);
        end
        tick();
        check("to_err", {31'd0, load_err_o}, 32'd1);
        check("to_stall_drop", {31'd0, stall_o}, 32'd0);
        check("to_we", {31'd0, we_o}, 32'd0);
        tick();
        check("to_err_pulse", {31'd0, load_err_o}, 32'd0);
`else
        for (int i = 0; i < 8; i++) begin
            tick();
            check("wait_stall", {31'd0, stall_o}, 32'd1);
            check("wait_err", {31'd0, load_err_o}, 32'd0);
            check("wait_we", {31'd0, we_o}, 32'd0);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("wait_flush_stall", {31'd0, stall_o}, 32'd0);
`endif

        // write something non-zero so reset clearing is visible, then reset mid-WAIT
        present_alu(5'd3, 32'h0000_3333);
        tick();
        present_load(3'b010, 2'd0, 5'd10);
        tick();
        mem_valid_i   = 1'b0;
        rst           = 1'b1;
        flush_i       = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h5555_5555;
        tick();
        rst = 1'b0; flush_i = 1'b0; dmem_rvalid_i = 1'b0;
        check("rstw_we", {31'd0, we_o}, 32'd0);
        check("rstw_waddr", {27'd0, waddr_o}, 32'd0);
        check("rstw_wdata", wdata_o, 32'd0);
        check("rstw_stall", {31'd0, stall_o}, 32'd0);
        check("rstw_err", {31'd0, load_err_o}, 32'd0);
        present_alu(5'd11, 32'h0000_ABCD);
        tick();
        mem_valid_i = 1'b0;
        check("post_rst_we", {31'd0, we_o}, 32'd1);
        check("post_rst_waddr", {27'd0, waddr_o}, 32'd11);
        check("post_rst_wdata", wdata_o, 32'h0000_ABCD);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage between the memory stage and the register file write port (we/waddr/wdata).
- Holds one retiring instruction and waits for the data-memory read response on loads.
- Aligns and sign- or zero-extends load data, then issues exactly one register-file write per instruction.
- Stalls upstream while a load response is outstanding and drops in-flight work on flush.

Parameters:
- LOAD_TIMEOUT, 255: max cycles in WAIT before abandon (only with WB_LOAD_TIMEOUT_EN).
- TO_W, 8: timeout counter width; must hold LOAD_TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- flush_i  in  1  interrupt/branch flush; discards held and pending work.
- mem_valid_i  in  1  memory stage presents an instruction.
- mem_wreg_i  in  1  instruction writes rd.
- mem_waddr_i  in  5  rd address.
- mem_wdata_i  in  32  ALU/CSR result for non-loads.
- mem_is_load_i  in  1  instruction is a load.
- mem_ld_funct3_i  in  3  LB=000, LH=001, LW=010, LBU=100, LHU=101.
- mem_addr_lo_i  in  2  load byte offset.
- dmem_rvalid_i  in  1  read response valid.
- dmem_rdata_i  in  32  read response word.
- stall_o  out  1  upstream hold.
- we_o  out  1  register-file write enable.
- waddr_o  out  5  register-file write address.
- wdata_o  out  32  register-file write data.
- load_err_o  out  1  timeout pulse (feature only; tied 0 otherwise).

Behaviour:
- Reset values: state IDLE; we_o=0, waddr_o=0, wdata_o=0, stall_o=0, load_err_o=0; internal latches cleared.
- States: IDLE, WAIT, WRITE.
- stall_o = (state==WAIT), combinational from state.
- Capture happens at a clock edge when state!=WAIT and mem_valid_i=1.
- Non-load capture: we_o=mem_wreg_i && mem_waddr_i!=0 in the next cycle, with waddr_o/wdata_o registered. Latency 1. Next state IDLE.
- Load capture: latch waddr, funct3 and offset; go to WAIT; we_o=0.
- WAIT with dmem_rvalid_i=1: at the edge, compute the extended word, pulse we_o for one cycle, go to WRITE.
- WRITE behaves as IDLE for capture, so back-to-back instructions proceed with no bubble beyond the load wait.
- A response arriving in the same cycle as the load is captured is not accepted; the response is only valid in WAIT.
- Extraction: shift dmem_rdata_i right by offset*8.
  - LB/LBU use bits[7:0] and LH/LHU use bits[15:0], sign- or zero-extended to 32 bits.
  - LW ignores offset.
  - Undefined funct3 writes 0.
- x0: we_o is never asserted for waddr 0. This is required because the register-file bypass would otherwise forward non-zero data for reads of x0.
- we_o is always a single-cycle pulse per instruction. It is 0 in every cycle without a write.
- flush_i=1 at an edge: state IDLE, we_o=0, nothing captured that cycle.
  - flush_i takes priority over a simultaneous dmem_rvalid_i and over capture.
  - A dmem_rvalid_i arriving in IDLE/WRITE is ignored.
- rst has priority over flush_i. Reset mid-WAIT returns to IDLE with no write.

Optional Feature:
- Macro: WB_LOAD_TIMEOUT_EN.
- Defined:
  - A TO_W counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches LOAD_TIMEOUT with no response: load_err_o pulses 1 cycle, state goes to IDLE, and no write is issued.
  - A response in that same cycle wins; no error.
- Undefined: no counter; WAIT persists until a response, flush or reset; load_err_o tied 0.

Decomposition:
- yadan_defs.v holds:
  - RegBus, RegAddrBus, ZeroWord, WriteEnable/WriteDisable.
  - Load funct3 codes.
  - State encodings WB_IDLE/WB_WAIT/WB_WRITE.
- One combinational sub-module, wb_load_ext: data, funct3 and offset in; 32-bit extended word out.

Test Plan:
- ADD: waddr=5, wdata=0x1234 -> next cycle we_o=1, waddr_o=5, wdata_o=0x1234; following cycle we_o=0.
- LB, offset=2, rdata=0x00800000, response 3 cycles after capture -> stall_o=1 for 3 cycles, then we_o=1, wdata_o=0xFFFFFF80; LBU same -> 0x00000080.
- LH, offset=2, rdata=0x8001ABCD -> 0xFFFF8001. LW back-to-back with ADD, waddr=0 -> we_o never 1 for x0.
- Flush asserted in WAIT while dmem_rvalid_i=1 -> no write, state IDLE, stall_o=0 next cycle; a later stray rvalid is ignored.
- Feature on, LOAD_TIMEOUT=4, no response -> load_err_o pulses after 4 WAIT cycles, we_o stays 0, stall_o drops.
- rst asserted during WAIT -> all outputs 0 the next cycle; a fresh ADD afterwards writes normally.
